// File: rtl/la_capture_core.sv
// Logic-analyzer capture core: circular probe buffer with a pre-trigger window,
// masked level/edge trigger with any/all combining, and a chronological read port.
module la_capture_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned TRIG_W = 4,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic [TRIG_W-1:0] i_trig,
  input  logic [TRIG_W-1:0] i_trig_mask,
  input  logic              i_trig_mode,
  input  logic              i_trig_and,
  input  logic [ADDR_W-1:0] i_pretrig,
  input  logic              i_arm,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_armed,
  output logic              o_triggered,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_trig_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] pretrig_q;
  logic [TRIG_W-1:0] mask_q;
  logic              mode_q;
  logic              and_q;
  logic [TRIG_W-1:0] trig_prev;

  logic [TRIG_W-1:0] hit_c;
  logic              trig_c;
  logic              wr_en_c;
  logic [ADDR_W-1:0] rd_idx_c;

  // Per-channel hit, then any/all combine; an empty mask can never fire.
  assign hit_c    = mask_q & (mode_q ? (i_trig & ~trig_prev) : i_trig);
  assign trig_c   = (mask_q != '0) && (and_q ? (hit_c == mask_q) : (hit_c != '0));
  assign wr_en_c  = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  assign rd_idx_c = o_trig_addr - pretrig_q + i_rd_addr;

  // Sample storage; contents are don't-care until a capture completes.
  always_ff @(posedge i_clk) begin
    if (wr_en_c) mem[wr_ptr] <= i_data;
  end

  // Capture sequencer and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      pretrig_q   <= '0;
      mask_q      <= '0;
      mode_q      <= 1'b0;
      and_q       <= 1'b0;
      trig_prev   <= '0;
      o_rd_data   <= '0;
      o_rd_valid  <= 1'b0;
      o_armed     <= 1'b0;
      o_triggered <= 1'b0;
      o_done      <= 1'b0;
      o_trig_addr <= '0;
    end else begin
      trig_prev  <= i_trig;
      o_rd_valid <= 1'b0;
      if (i_arm) begin
        pretrig_q   <= i_pretrig;
        mask_q      <= i_trig_mask;
        mode_q      <= i_trig_mode;
        and_q       <= i_trig_and;
        wr_ptr      <= '0;
        pre_cnt     <= '0;
        o_triggered <= 1'b0;
        o_done      <= 1'b0;
        o_armed     <= 1'b1;
        state       <= (i_pretrig != '0) ? S_PRE : S_WAIT;
      end else begin
        case (state)
          S_PRE: begin
            wr_ptr  <= wr_ptr + ADDR_W'(1);
            pre_cnt <= pre_cnt + ADDR_W'(1);
            if (pre_cnt + ADDR_W'(1) == pretrig_q) state <= S_WAIT;
          end
          S_WAIT: begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (trig_c) begin
              o_trig_addr <= wr_ptr;
              o_triggered <= 1'b1;
              post_cnt    <= ADDR_W'(DEPTH - 1) - pretrig_q;
              // A full pre-trigger window leaves no post samples to take.
              if (pretrig_q == ADDR_W'(DEPTH - 1)) begin
                state   <= S_DONE;
                o_done  <= 1'b1;
                o_armed <= 1'b0;
              end else begin
                state <= S_POST;
              end
            end
          end
          S_POST: begin
            wr_ptr   <= wr_ptr + ADDR_W'(1);
            post_cnt <= post_cnt - ADDR_W'(1);
            if (post_cnt == ADDR_W'(1)) begin
              state   <= S_DONE;
              o_done  <= 1'b1;
              o_armed <= 1'b0;
            end
          end
          S_DONE: begin
            if (i_rd_en) begin
              o_rd_data  <= mem[rd_idx_c];
              o_rd_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_la_capture_core.sv
// Bench for la_capture_core: directed scenarios plus randomized captures, each
// checked against a history-based model of which sample fires and what is kept.
module tb_la_capture_core;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned TRIG_W = 4;
  localparam int unsigned ADDR_W = 4;

  logic              i_clk;
  logic              i_rst;
  logic [DATA_W-1:0] i_data;
  logic [TRIG_W-1:0] i_trig;
  logic [TRIG_W-1:0] i_trig_mask;
  logic              i_trig_mode;
  logic              i_trig_and;
  logic [ADDR_W-1:0] i_pretrig;
  logic              i_arm;
  logic              i_rd_en;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_valid;
  logic              o_armed;
  logic              o_triggered;
  logic              o_done;
  logic [ADDR_W-1:0] o_trig_addr;

  la_capture_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TRIG_W(TRIG_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_trig(i_trig),
    .i_trig_mask(i_trig_mask), .i_trig_mode(i_trig_mode), .i_trig_and(i_trig_and),
    .i_pretrig(i_pretrig), .i_arm(i_arm), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_armed(o_armed),
    .o_triggered(o_triggered), .o_done(o_done), .o_trig_addr(o_trig_addr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int errs = 0;
  int checks = 0;
  // Input values present at each clock edge, indexed by edge number.
  logic [DATA_W-1:0] hist_data[$];
  logic [TRIG_W-1:0] hist_trig[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    hist_data.push_back(i_data);
    hist_trig.push_back(i_trig);
    @(posedge i_clk);
    #1;
    i_data = i_data + 8'd1;
  endtask

  task automatic goto_data(input logic [DATA_W-1:0] v);
    int n;
    n = 0;
    while (i_data != v && n < 300) begin
      step();
      n++;
    end
  endtask

  // Edge index of the first sample that satisfies the trigger rule once the
  // pre-trigger writes are done, or -1 if none in the recorded history.
  function automatic int model_trig(input int arm_idx, input int pt, input logic [3:0] mask,
                                    input logic mode, input logic andm);
    int en;
    int hit;
    logic cur;
    logic prev;
    for (int k = arm_idx + 1 + pt; k < hist_trig.size(); k++) begin
      en = 0;
      hit = 0;
      for (int ch = 0; ch < TRIG_W; ch++) begin
        if (mask[ch]) begin
          en++;
          cur  = hist_trig[k][ch];
          prev = hist_trig[k-1][ch];
          if (mode ? (cur && !prev) : cur) hit++;
        end
      end
      if (en > 0 && (andm ? (hit == en) : (hit > 0))) return k;
    end
    return -1;
  endfunction

  task automatic arm(input int pt, input logic [3:0] mask, input logic mode,
                     input logic andm, output int arm_idx);
    i_pretrig   = 4'(pt);
    i_trig_mask = mask;
    i_trig_mode = mode;
    i_trig_and  = andm;
    i_arm       = 1'b1;
    arm_idx     = hist_data.size();
    step();
    i_arm = 1'b0;
    chk("arm_armed", 32'(o_armed), 1);
    chk("arm_trig_clr", 32'(o_triggered), 0);
    chk("arm_done_clr", 32'(o_done), 0);
  endtask

  task automatic wait_done(input bit rnd, output int done_idx);
    int n;
    n = 0;
    while (!o_done && n < 600) begin
      if (rnd) i_trig = 4'($urandom);
      step();
      n++;
    end
    chk("done_reached", 32'(o_done), 1);
    done_idx = hist_data.size() - 1;
  endtask

  task automatic read_at(input string tag, input int addr, input logic [DATA_W-1:0] exp);
    i_rd_en   = 1'b1;
    i_rd_addr = 4'(addr);
    step();
    i_rd_en = 1'b0;
    chk(tag, 32'(o_rd_data), 32'(exp));
  endtask

  // Wait for completion, then compare status, trigger index and every sample.
  task automatic check_capture(input int arm_idx, input int pt, input logic [3:0] mask,
                               input logic mode, input logic andm, input bit rnd,
                               output int k, output int done_idx);
    wait_done(rnd, done_idx);
    k = model_trig(arm_idx, pt, mask, mode, andm);
    chk("model_trig_found", 32'(k >= 0), 1);
    if (k >= 0) begin
      chk("done_cycle", 32'(done_idx), 32'(k + int'(DEPTH) - 1 - pt));
      chk("triggered", 32'(o_triggered), 1);
      chk("armed_after_done", 32'(o_armed), 0);
      chk("trig_addr", 32'(o_trig_addr), 32'((k - arm_idx - 1) % int'(DEPTH)));
      i_rd_en = 1'b1;
      for (int a = 0; a < int'(DEPTH); a++) begin
        i_rd_addr = 4'(a);
        step();
        chk("rd_valid", 32'(o_rd_valid), 1);
        chk("rd_data", 32'(o_rd_data), 32'(hist_data[k - pt + a]));
      end
      i_rd_en = 1'b0;
      step();
      chk("rd_valid_drop", 32'(o_rd_valid), 0);
    end
  endtask

  initial begin
    int a_idx;
    int k;
    int d_idx;
    int t_idx;
    int pt;
    logic [3:0] mask;
    logic mode;
    logic andm;

    i_rst = 1'b1;
    i_data = '0; i_trig = '0; i_trig_mask = '0; i_trig_mode = 1'b0; i_trig_and = 1'b0;
    i_pretrig = '0; i_arm = 1'b0; i_rd_en = 1'b0; i_rd_addr = '0;

    // Reset with random inputs, then idle with no arm.
    for (int i = 0; i < 10; i++) begin
      if (i == 4) i_rst = 1'b0;
      i_trig = 4'($urandom); i_trig_mask = 4'($urandom); i_trig_mode = 1'($urandom);
      i_trig_and = 1'($urandom); i_pretrig = 4'($urandom); i_rd_en = 1'($urandom);
      i_rd_addr = 4'($urandom);
      i_arm = (i < 4) ? 1'($urandom) : 1'b0;
      step();
      chk("reset_outputs_zero",
          32'({o_rd_data, o_rd_valid, o_armed, o_triggered, o_done, o_trig_addr}), 0);
    end
    i_rd_en = 1'b0;
    i_trig = '0;
    i_data = '0;

    // Level trigger, pretrig 4, fire at data 40.
    goto_data(30);
    arm(4, 4'b0001, 1'b0, 1'b0, a_idx);
    goto_data(40);
    i_trig = 4'b0001;
    step();
    t_idx = hist_data.size() - 1;
    check_capture(a_idx, 4, 4'b0001, 1'b0, 1'b0, 1'b0, k, d_idx);
    chk("s2_done_latency", 32'(d_idx - t_idx + 1), 12);
    read_at("s2_addr0", 0, 8'd36);
    read_at("s2_addr4", 4, 8'd40);
    read_at("s2_addr15", 15, 8'd51);
    i_trig = '0;

    // Edge mode: channel high before arm must not fire until it falls and rises.
    i_trig = 4'b0001;
    step();
    arm(2, 4'b0001, 1'b1, 1'b0, a_idx);
    for (int i = 0; i < 10; i++) step();
    chk("edge_held_no_trig", 32'(o_triggered), 0);
    i_trig = '0;
    step();
    goto_data(70);
    i_trig = 4'b0001;
    step();
    check_capture(a_idx, 2, 4'b0001, 1'b1, 1'b0, 1'b0, k, d_idx);
    read_at("edge_trig_sample", 2, 8'd70);
    i_trig = '0;

    // AND mode over two channels, then an empty mask.
    arm(3, 4'b0011, 1'b0, 1'b1, a_idx);
    i_trig = 4'b0001;
    for (int i = 0; i < 8; i++) step();
    chk("and_partial_no_trig", 32'(o_triggered), 0);
    goto_data(90);
    i_trig = 4'b0011;
    step();
    check_capture(a_idx, 3, 4'b0011, 1'b0, 1'b1, 1'b0, k, d_idx);
    read_at("and_trig_sample", 3, 8'd90);
    i_trig = '0;
    arm(1, 4'b0000, 1'b0, 1'b0, a_idx);
    i_trig = 4'b1111;
    for (int i = 0; i < 40; i++) step();
    chk("mask0_no_trig", 32'(o_triggered), 0);
    chk("mask0_no_done", 32'(o_done), 0);
    chk("mask0_still_armed", 32'(o_armed), 1);
    i_trig = '0;

    // Full pre-trigger window; a pulse during PRE is ignored.
    goto_data(100);
    arm(15, 4'b0001, 1'b0, 1'b0, a_idx);
    step(); step();
    i_trig = 4'b0001;
    step();
    i_trig = '0;
    chk("pre_pulse_ignored", 32'(o_triggered), 0);
    goto_data(120);
    i_trig = 4'b0001;
    step();
    t_idx = hist_data.size() - 1;
    check_capture(a_idx, 15, 4'b0001, 1'b0, 1'b0, 1'b0, k, d_idx);
    chk("pt15_done_latency", 32'(d_idx - t_idx + 1), 1);
    read_at("pt15_addr15", 15, 8'd120);
    read_at("pt15_addr0", 0, 8'd105);
    i_trig = '0;

    // Re-arm during POST restarts the capture.
    arm(2, 4'b0001, 1'b0, 1'b0, a_idx);
    step(); step(); step();
    i_trig = 4'b0001;
    step(); step();
    chk("post_triggered", 32'(o_triggered), 1);
    chk("post_not_done", 32'(o_done), 0);
    i_trig = '0;
    arm(2, 4'b0001, 1'b0, 1'b0, a_idx);
    i_trig = 4'b0001;
    check_capture(a_idx, 2, 4'b0001, 1'b0, 1'b0, 1'b0, k, d_idx);
    i_trig = '0;

    // Asynchronous reset mid-WAIT, then reads are ignored.
    arm(0, 4'b0001, 1'b0, 1'b0, a_idx);
    step(); step(); step();
    i_rst = 1'b1;
    #1;
    chk("midwait_reset_zero",
        32'({o_rd_data, o_rd_valid, o_armed, o_triggered, o_done, o_trig_addr}), 0);
    step();
    i_rst = 1'b0;
    i_rd_en = 1'b1;
    i_rd_addr = 4'd5;
    step();
    chk("idle_read_ignored", 32'(o_rd_valid), 0);
    chk("idle_not_armed", 32'(o_armed), 0);
    i_rd_en = 1'b0;

    // Randomized captures checked against the history model.
    for (int r = 0; r < 5; r++) begin
      pt   = (r == 0) ? 0 : int'($urandom_range(15));
      mode = 1'($urandom);
      andm = 1'($urandom);
      mask = 4'($urandom_range(15, 1));
      if (mode && andm) mask = 4'(1 << $urandom_range(3)) | 4'(1 << $urandom_range(3));
      i_trig = 4'($urandom);
      arm(pt, mask, mode, andm, a_idx);
      check_capture(a_idx, pt, mask, mode, andm, 1'b1, k, d_idx);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
